// File: rtl/vc_alloc_rr_stateful.sv
// rtl/vc_alloc_rr_stateful.sv - separable input-first VC allocator, registered grants, output-VC ownership
// Optional VC_CLASS_EN: restricts stage-1 candidates to output VCs of the requester's class.
module vc_alloc_rr_stateful #(
    parameter int NUM_PORTS   = 5,
    parameter int NUM_VCS     = 4,
    parameter int NUM_CLASSES = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_PORTS*NUM_VCS-1:0]                 req_valid,
    input  logic [NUM_PORTS*NUM_VCS*NUM_PORTS-1:0]       req_dst,
    input  logic [NUM_PORTS*NUM_VCS-1:0]                 release_valid,
    output logic [NUM_PORTS*NUM_VCS-1:0]                 grant_valid,
    output logic [NUM_PORTS*NUM_VCS*$clog2(NUM_VCS)-1:0] grant_ovc,
    output logic [NUM_PORTS*NUM_VCS-1:0]                 ovc_busy,
    output logic                                         err_bad_dst
);
    localparam int N  = NUM_PORTS * NUM_VCS;
    localparam int VW = $clog2(NUM_VCS);
    localparam int GW = $clog2(N);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
`ifdef VC_CLASS_EN
    localparam bit CLASS_ON = 1'b1;
`else
    localparam bit CLASS_ON = 1'b0;
`endif
    // With classes off a single class spans all VCs, so the class match is always true.
    localparam int CLS_SIZE = CLASS_ON ? NUM_VCS / NUM_CLASSES : NUM_VCS;

    logic [VW-1:0] ptr1 [N];
    logic [GW-1:0] ptr2 [N];
    logic          hold;

    logic [N-1:0]  elig;
    logic [N-1:0]  bad;
    logic [N-1:0]  s1_valid;
    logic [N-1:0]  gnt_next;
    logic [N-1:0]  set_busy;
    logic [PW-1:0] dst_port [N];
    logic [GW-1:0] s1_sel   [N];
    logic [VW-1:0] s1_ovc   [N];
    logic [GW-1:0] win_idx  [N];

    always_comb begin : decode
        for (int i = 0; i < N; i++) begin
            dst_port[i] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (req_dst[i*NUM_PORTS+p]) dst_port[i] = PW'(p);
            end
            // A requester sees its grant a cycle late, so its still-high request is masked here.
            elig[i] = req_valid[i] && $onehot(req_dst[i*NUM_PORTS +: NUM_PORTS]) && !grant_valid[i];
            bad[i]  = req_valid[i] && !$onehot(req_dst[i*NUM_PORTS +: NUM_PORTS]);
        end
    end

    always_comb begin : stage1
        int idx;
        int g;
        idx = 0;
        g   = 0;
        for (int i = 0; i < N; i++) begin
            s1_valid[i] = 1'b0;
            s1_sel[i]   = '0;
            s1_ovc[i]   = '0;
            for (int k = 0; k < NUM_VCS; k++) begin
                idx = (int'(ptr1[i]) + k) % NUM_VCS;
                g   = int'(dst_port[i]) * NUM_VCS + idx;
                if (elig[i] && !s1_valid[i] && !ovc_busy[g] &&
                    ((i % NUM_VCS) / CLS_SIZE == idx / CLS_SIZE)) begin
                    s1_valid[i] = 1'b1;
                    s1_sel[i]   = GW'(g);
                    s1_ovc[i]   = VW'(idx);
                end
            end
        end
    end

    always_comb begin : stage2
        int   j;
        logic found;
        j        = 0;
        found    = 1'b0;
        gnt_next = '0;
        set_busy = '0;
        for (int o = 0; o < N; o++) begin
            win_idx[o] = '0;
            found      = 1'b0;
            for (int k = 0; k < N; k++) begin
                j = (int'(ptr2[o]) + k) % N;
                if (!found && s1_valid[j] && s1_sel[j] == GW'(o)) begin
                    found      = 1'b1;
                    win_idx[o] = GW'(j);
                end
            end
            if (found && !hold) begin
                set_busy[o]                = 1'b1;
                gnt_next[int'(win_idx[o])] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold        <= 1'b1;
            grant_valid <= '0;
            grant_ovc   <= '0;
            ovc_busy    <= '0;
            err_bad_dst <= 1'b0;
            for (int i = 0; i < N; i++) begin
                ptr1[i] <= '0;
                ptr2[i] <= '0;
            end
        end else begin
            // hold keeps the first cycle after reset grant-free.
            hold        <= 1'b0;
            grant_valid <= gnt_next;
            ovc_busy    <= (ovc_busy & ~release_valid) | set_busy;
            err_bad_dst <= |bad;
            for (int i = 0; i < N; i++) begin
                grant_ovc[i*VW +: VW] <= gnt_next[i] ? s1_ovc[i] : '0;
                if (gnt_next[i]) ptr1[i] <= VW'((int'(s1_ovc[i]) + 1) % NUM_VCS);
                if (set_busy[i]) ptr2[i] <= GW'((int'(win_idx[i]) + 1) % N);
            end
        end
    end
endmodule

// File: tb/tb_vc_alloc_rr_stateful.sv
// tb/tb_vc_alloc_rr_stateful.sv - scoreboard bench for vc_alloc_rr_stateful
module tb_vc_alloc_rr_stateful;
    localparam int NP = 5;
    localparam int NV = 4;
    localparam int N  = NP * NV;
    localparam int VW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*NP-1:0]   req_dst;
    logic [N-1:0]      release_valid;
    logic [N-1:0]      grant_valid;
    logic [N*VW-1:0]   grant_ovc;
    logic [N-1:0]      ovc_busy;
    logic              err_bad_dst;

    vc_alloc_rr_stateful #(.NUM_PORTS(NP), .NUM_VCS(NV), .NUM_CLASSES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_dst(req_dst),
        .release_valid(release_valid), .grant_valid(grant_valid), .grant_ovc(grant_ovc),
        .ovc_busy(ovc_busy), .err_bad_dst(err_bad_dst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    gv;
        logic [N*VW-1:0] gov;
        logic [N-1:0]    busy;
        logic            err;
    } exp_t;

    exp_t            sb[$];
    exp_t            cur;
    int              checks = 0;
    int              failures = 0;
    logic [N-1:0]    e_gv, e_busy;
    logic [N*VW-1:0] e_gov;
    logic            e_err;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            check("grant_valid", 64'(grant_valid), 64'(cur.gv));
            check("grant_ovc", 64'(grant_ovc), 64'(cur.gov));
            check("ovc_busy", 64'(ovc_busy), 64'(cur.busy));
            check("err_bad_dst", 64'(err_bad_dst), 64'(cur.err));
        end
    end

    task automatic cyc();
        exp_t x;
        x.gv = e_gv; x.gov = e_gov; x.busy = e_busy; x.err = e_err;
        sb.push_back(x);
        e_gv = '0; e_gov = '0; e_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input int i, input int g);
        e_gv[i] = 1'b1;
        e_gov[i*VW +: VW] = VW'(g % NV);
        e_busy[g] = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [NP-1:0] d);
        req_valid[i] = 1'b1;
        req_dst[i*NP +: NP] = d;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; release_valid = '0; e_busy = '0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_dst = '0; release_valid = '0;
        e_gv = '0; e_gov = '0; e_busy = '0; e_err = 1'b0;

        // reset with every input VC requesting a valid port
        for (int i = 0; i < N; i++) set_req(i, 5'b00001);
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        req_valid = '0;
        cyc();

        // single request, held one extra cycle, then release
        do_reset();
        set_req(0, 5'b00100);
        exp_grant(0, 8); cyc();
        cyc();
        clr_req(0); cyc();
        release_valid[8] = 1'b1; e_busy[8] = 1'b0; cyc();
        release_valid[8] = 1'b0;

        // contention on port 1
        do_reset();
        for (int v = 0; v < N; v += NV) set_req(v, 5'b00010);
        exp_grant(0, 4);  cyc(); clr_req(0);
        exp_grant(4, 5);  cyc(); clr_req(4);
        exp_grant(8, 6);  cyc(); clr_req(8);
        exp_grant(12, 7); cyc(); clr_req(12);
        cyc(); cyc();

        // release of ovc 5 lets the waiting VC16 in
        release_valid[5] = 1'b1; e_busy[5] = 1'b0; cyc();
        release_valid[5] = 1'b0;
        exp_grant(16, 5); cyc(); clr_req(16);
        cyc();

        // bad destinations: multi-hot then zero
        set_req(3, 5'b00110); e_err = 1'b1; cyc();
        req_dst[3*NP +: NP] = '0; e_err = 1'b1; cyc();
        clr_req(3); cyc();

        // classes: ovc 8,9 owned, then class-0 and class-1 requesters at port 2
        do_reset();
        set_req(0, 5'b00100); exp_grant(0, 8); cyc(); clr_req(0);
        set_req(4, 5'b00100); exp_grant(4, 9); cyc(); clr_req(4);
        set_req(1, 5'b00100);
`ifdef VC_CLASS_EN
        cyc(); cyc(); clr_req(1);
        set_req(2, 5'b00100); exp_grant(2, 10); cyc(); clr_req(2);
        cyc();
`else
        exp_grant(1, 10); cyc(); clr_req(1);
        set_req(2, 5'b00100); exp_grant(2, 11); cyc(); clr_req(2);
        cyc();
`endif

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
